// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer controller: state encoding,
// parameter defaults and a counter-width helper.
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } bus_xfer_state_e;

  localparam int BUS_XFER_TURN_CYC_DEF = 1;
  localparam int BUS_XFER_TIMEOUT_DEF  = 15;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl.sv
// Single-transfer controller for a shared tri-state bus: IDLE -> WRITE/READ -> TURN -> IDLE.
// Optional ack timeout is enabled with the macro BUS_XFER_CTRL_TIMEOUT_EN.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter type T        = logic [7:0],
  parameter int  TURN_CYC = BUS_XFER_TURN_CYC_DEF,
  parameter int  TIMEOUT  = BUS_XFER_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  T           req_data,
  output logic       rsp_valid,
  output T           rsp_data,
  output logic       rsp_err,
  output logic       bus_rw,
  output T           bus_wdata,
  input  T           bus_in,
  input  logic       bus_ack,
  output logic [1:0] dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no
  // backpressure, and rsp_err / rsp_data are meaningful only alongside it.

  localparam int TURN_W = cnt_w(TURN_CYC);

  bus_xfer_state_e   state_q, state_d;
  logic              bus_rw_q, bus_rw_d;
  logic              rsp_valid_q, rsp_valid_d;
  T                  bus_wdata_q, bus_wdata_d;
  T                  rsp_data_q, rsp_data_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;

`ifdef BUS_XFER_CTRL_TIMEOUT_EN
  localparam int WAIT_W = cnt_w(TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              rsp_err_q, rsp_err_d;
  logic              wait_last;

  // The cycle where the counter reads TIMEOUT-1 is the last one an ack may use.
  assign wait_last = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    bus_rw_d    = 1'b0;
    rsp_valid_d = 1'b0;
    bus_wdata_d = bus_wdata_q;
    rsp_data_d  = rsp_data_q;
    turn_cnt_d  = turn_cnt_q;
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = req_write ? WRITE : READ;
          bus_rw_d   = req_write;
          turn_cnt_d = '0;
          if (req_write) begin
            bus_wdata_d = req_data;
          end
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      WRITE: begin
        bus_rw_d = 1'b1;
        if (bus_ack) begin
          state_d     = TURN;
          bus_rw_d    = 1'b0;
          rsp_valid_d = 1'b1;
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
        end else if (wait_last) begin
          state_d     = TURN;
          bus_rw_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
        end
      end

      READ: begin
        if (bus_ack) begin
          state_d     = TURN;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus_in;
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
        end else if (wait_last) begin
          state_d     = TURN;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
        end
      end

      TURN: begin
        if (turn_cnt_q == TURN_W'(TURN_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset is asynchronous so bus_rw releases the shared bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_rw_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      bus_wdata_q <= '0;
      rsp_data_q  <= '0;
      turn_cnt_q  <= '0;
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_rw_q    <= bus_rw_d;
      rsp_valid_q <= rsp_valid_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_data_q  <= rsp_data_d;
      turn_cnt_q  <= turn_cnt_d;
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign bus_rw    = bus_rw_q;
  assign bus_wdata = bus_wdata_q;
  assign dbg_state = state_q;
`ifdef BUS_XFER_CTRL_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed testbench for bus_xfer_ctrl with TURN_CYC=1, TIMEOUT=4; the timeout
// section follows BUS_XFER_CTRL_TIMEOUT_EN.
module tb_bus_xfer_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       bus_rw;
  logic [7:0] bus_wdata;
  logic [7:0] bus_in;
  logic       bus_ack;
  logic [1:0] dbg_state;

  int errors;
  int checks;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_xfer_ctrl #(
    .T        (logic [7:0]),
    .TURN_CYC (1),
    .TIMEOUT  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_rw    (bus_rw),
    .bus_wdata (bus_wdata),
    .bus_in    (bus_in),
    .bus_ack   (bus_ack),
    .dbg_state (dbg_state)
  );

  // Driver: advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] d,
                       input logic ack, input logic [7:0] bin);
    req_valid = v;
    req_write = w;
    req_data  = d;
    bus_ack   = ack;
    bus_in    = bin;
  endtask

  // Scoreboard comparison point
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    tick();

    // Reset state
    chk("rst_state", {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("rst_bus_rw", {7'd0, bus_rw}, 8'd0);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_rsp_err", {7'd0, rsp_err}, 8'd0);
    chk("rst_wdata", bus_wdata, 8'h00);
    chk("rst_rdata", rsp_data, 8'h00);
    chk("rst_ready", {7'd0, req_ready}, 8'd1);
    rst_n = 1'b1;
    tick();

    // Write A5, ack in first WRITE cycle
    drive(1'b1, 1'b1, 8'hA5, 1'b1, 8'h00);
    tick();
    chk("wr_state", {6'd0, dbg_state}, {6'd0, S_WRITE});
    chk("wr_bus_rw", {7'd0, bus_rw}, 8'd1);
    chk("wr_wdata", bus_wdata, 8'hA5);
    chk("wr_ready", {7'd0, req_ready}, 8'd0);
    chk("wr_rsp_early", {7'd0, rsp_valid}, 8'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    tick();
    chk("wr_turn", {6'd0, dbg_state}, {6'd0, S_TURN});
    chk("wr_rw_drop", {7'd0, bus_rw}, 8'd0);
    chk("wr_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("wr_rsp_err", {7'd0, rsp_err}, 8'd0);
    tick();
    chk("wr_ready_back", {7'd0, req_ready}, 8'd1);
    chk("wr_rsp_single", {7'd0, rsp_valid}, 8'd0);

    // Read 3C, ack after two wait cycles
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h3C);
    tick();
    chk("rd_state", {6'd0, dbg_state}, {6'd0, S_READ});
    chk("rd_rw0", {7'd0, bus_rw}, 8'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h3C);
    tick();
    chk("rd_wait1", {6'd0, dbg_state}, {6'd0, S_READ});
    chk("rd_rw1", {7'd0, bus_rw}, 8'd0);
    tick();
    chk("rd_wait2_rsp", {7'd0, rsp_valid}, 8'd0);
    bus_ack = 1'b1;
    tick();
    chk("rd_turn", {6'd0, dbg_state}, {6'd0, S_TURN});
    chk("rd_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("rd_rsp_data", rsp_data, 8'h3C);
    chk("rd_rsp_err", {7'd0, rsp_err}, 8'd0);
    chk("rd_rw_turn", {7'd0, bus_rw}, 8'd0);
    bus_ack = 1'b0;
    tick();
    chk("rd_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});

    // Back-to-back write then read with req_valid held
    drive(1'b1, 1'b1, 8'h5A, 1'b1, 8'h77);
    tick();
    chk("b2b_wr", {6'd0, dbg_state}, {6'd0, S_WRITE});
    drive(1'b1, 1'b0, 8'hEE, 1'b1, 8'h77);
    tick();
    chk("b2b_turn", {6'd0, dbg_state}, {6'd0, S_TURN});
    chk("b2b_turn_rw", {7'd0, bus_rw}, 8'd0);
    tick();
    chk("b2b_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("b2b_idle_rw", {7'd0, bus_rw}, 8'd0);
    bus_ack = 1'b0;
    tick();
    chk("b2b_rd", {6'd0, dbg_state}, {6'd0, S_READ});
    chk("b2b_rd_rw", {7'd0, bus_rw}, 8'd0);
    chk("b2b_wdata_hold", bus_wdata, 8'h5A);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h77);
    tick();
    chk("b2b_rd_data", rsp_data, 8'h77);
    chk("b2b_rd_valid", {7'd0, rsp_valid}, 8'd1);
    bus_ack = 1'b0;
    tick();

    // req_valid during READ, ack pulses in TURN
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h11);
    tick();
    drive(1'b1, 1'b1, 8'h44, 1'b0, 8'h11);
    tick();
    chk("ign_rd_hold", {6'd0, dbg_state}, {6'd0, S_READ});
    chk("ign_rd_rw", {7'd0, bus_rw}, 8'd0);
    drive(1'b1, 1'b1, 8'h44, 1'b1, 8'h22);
    tick();
    chk("ign_turn_data", rsp_data, 8'h22);
    drive(1'b1, 1'b1, 8'h44, 1'b1, 8'h99);
    tick();
    chk("ign_turn_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("ign_no_rsp", {7'd0, rsp_valid}, 8'd0);
    chk("ign_data_keep", rsp_data, 8'h22);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk("ign_idle2", {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("ign_no_rsp2", {7'd0, rsp_valid}, 8'd0);

    // Reset in the middle of a WRITE
    drive(1'b1, 1'b1, 8'hC3, 1'b0, 8'h00);
    tick();
    chk("mr_wr", {7'd0, bus_rw}, 8'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rw_async", {7'd0, bus_rw}, 8'd0);
    chk("mr_state_async", {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("mr_wdata", bus_wdata, 8'h00);
    tick();
    chk("mr_no_rsp", {7'd0, rsp_valid}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_ready", {7'd0, req_ready}, 8'd1);
    chk("mr_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});
    chk("mr_no_rsp2", {7'd0, rsp_valid}, 8'd0);

`ifdef BUS_XFER_CTRL_TIMEOUT_EN
    // Ack in the final allowed cycle is a success
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h5E);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("to_c4_state", {6'd0, dbg_state}, {6'd0, S_READ});
    bus_ack = 1'b1;
    tick();
    chk("to_last_valid", {7'd0, rsp_valid}, 8'd1);
    chk("to_last_err", {7'd0, rsp_err}, 8'd0);
    chk("to_last_data", rsp_data, 8'h5E);
    bus_ack = 1'b0;
    tick();

    // No ack: timeout after four READ cycles, data unchanged
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'hAA);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("to_wait_state", {6'd0, dbg_state}, {6'd0, S_READ});
    chk("to_wait_rsp", {7'd0, rsp_valid}, 8'd0);
    tick();
    chk("to_turn", {6'd0, dbg_state}, {6'd0, S_TURN});
    chk("to_valid", {7'd0, rsp_valid}, 8'd1);
    chk("to_err", {7'd0, rsp_err}, 8'd1);
    chk("to_data_keep", rsp_data, 8'h5E);
    tick();
    chk("to_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});
`else
    // Without timeout a READ waits for as long as ack is absent
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'hAA);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("nt_wait_state", {6'd0, dbg_state}, {6'd0, S_READ});
    chk("nt_wait_rsp", {7'd0, rsp_valid}, 8'd0);
    bus_ack = 1'b1;
    tick();
    chk("nt_valid", {7'd0, rsp_valid}, 8'd1);
    chk("nt_err", {7'd0, rsp_err}, 8'd0);
    chk("nt_data", rsp_data, 8'hAA);
    bus_ack = 1'b0;
    tick();
    chk("nt_idle", {6'd0, dbg_state}, {6'd0, S_IDLE});
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
